// File: rtl/dmem_bus_arbiter_pkg.sv
// rtl/dmem_bus_arbiter_pkg.sv - shared types and round-robin pick for the data-memory bus arbiter
package dmem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_C = 1'b0,
    OWNER_L = 1'b1
  } owner_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  localparam int unsigned DEFAULT_MAX_WAIT = 15;

  // A lone requester always wins; on a tie the port that did not go last wins.
  function automatic owner_e pick_owner(input logic c_req, input logic l_req, input owner_e last);
    owner_e w_pick;
    if (c_req && l_req) begin
      w_pick = (last == OWNER_C) ? OWNER_L : OWNER_C;
    end else begin
      w_pick = c_req ? OWNER_C : OWNER_L;
    end
    return w_pick;
  endfunction

endpackage

// File: rtl/dmem_bus_arbiter_if.sv
// rtl/dmem_bus_arbiter_if.sv - requester and memory-side signals of the data-memory bus arbiter
interface dmem_bus_arbiter_if;
  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_be;
  logic        c_done;
  logic [31:0] c_rdata;
  logic        c_err;

  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [3:0]  l_be;
  logic        l_done;
  logic [31:0] l_rdata;
  logic        l_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        core_stall;

  modport master (
    input  c_req, c_we, c_addr, c_wdata, c_be,
    output c_done, c_rdata, c_err,
    input  l_req, l_we, l_addr, l_wdata, l_be,
    output l_done, l_rdata, l_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output core_stall
  );

  modport slave (
    output c_req, c_we, c_addr, c_wdata, c_be,
    input  c_done, c_rdata, c_err,
    output l_req, l_we, l_addr, l_wdata, l_be,
    input  l_done, l_rdata, l_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  core_stall
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// rtl/dmem_bus_arbiter.sv - two-port round-robin arbiter sharing one data-memory bus
// Sequences IDLE -> ISSUE -> (WAIT_RD) -> RESP with a bounded read wait.
module dmem_bus_arbiter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input logic                 clock,
  input logic                 reset,
  dmem_bus_arbiter_if.master  bus
);

  localparam int unsigned          CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAX_WAIT);

  state_e           r_state;
  owner_e           r_owner;
  owner_e           r_last_owner;
  cmd_t             r_cmd;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  state_e           w_state_nxt;
  owner_e           w_owner_nxt;
  owner_e           w_last_owner_nxt;
  owner_e           w_pick;
  cmd_t             w_cmd_nxt;
  cmd_t             w_c_cmd;
  cmd_t             w_l_cmd;
  logic [31:0]      w_rdata_nxt;
  logic             w_err_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_c_done;
  logic             w_l_done;

  assign w_c_cmd = '{we: bus.c_we, addr: bus.c_addr, wdata: bus.c_wdata, be: bus.c_be};
  assign w_l_cmd = '{we: bus.l_we, addr: bus.l_addr, wdata: bus.l_wdata, be: bus.l_be};
  assign w_pick  = pick_owner(bus.c_req, bus.l_req, r_last_owner);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWNER_C;
      r_last_owner <= OWNER_L;
      r_cmd        <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_cmd        <= w_cmd_nxt;
      r_rdata      <= w_rdata_nxt;
      r_err        <= w_err_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_cmd_nxt        = r_cmd;
    w_rdata_nxt      = r_rdata;
    w_err_nxt        = r_err;
    w_cnt_nxt        = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (bus.c_req || bus.l_req) begin
          w_owner_nxt = w_pick;
          w_cmd_nxt   = (w_pick == OWNER_C) ? w_c_cmd : w_l_cmd;
          w_state_nxt = ST_ISSUE;
        end
      end

      // No timeout here: the memory may legitimately hold off a grant.
      ST_ISSUE: begin
        if (bus.mem_gnt) begin
          if (r_cmd.we) begin
            w_err_nxt   = 1'b0;
            w_state_nxt = ST_RESP;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT_RD;
          end
        end
      end

      ST_WAIT_RD: begin
        if (bus.mem_rvalid) begin
          w_rdata_nxt = bus.mem_rdata;
          w_err_nxt   = 1'b0;
          w_state_nxt = ST_RESP;
        end else if (r_cnt == CNT_MAX) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_RESP: begin
        w_last_owner_nxt = r_owner;
        w_state_nxt      = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_c_done = (r_state == ST_RESP) && (r_owner == OWNER_C);
  assign w_l_done = (r_state == ST_RESP) && (r_owner == OWNER_L);

  assign bus.c_done  = w_c_done;
  assign bus.c_rdata = w_c_done ? r_rdata : '0;
  assign bus.c_err   = w_c_done & r_err;
  assign bus.l_done  = w_l_done;
  assign bus.l_rdata = w_l_done ? r_rdata : '0;
  assign bus.l_err   = w_l_done & r_err;

  // Bus fields come only from the latched command, never straight from a requester.
  assign bus.mem_req   = (r_state == ST_ISSUE);
  assign bus.mem_we    = r_cmd.we;
  assign bus.mem_addr  = r_cmd.addr;
  assign bus.mem_wdata = r_cmd.wdata;
  assign bus.mem_be    = r_cmd.be;

  assign bus.core_stall = bus.c_req & ~w_c_done;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb/tb_dmem_bus_arbiter.sv - scoreboard bench for the data-memory bus arbiter
module tb_dmem_bus_arbiter;
  import dmem_bus_arbiter_pkg::*;

  localparam int MAX_WAIT = 15;

  typedef struct {
    bit          port;
    bit          chk_rd;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } done_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   unexp_done = 0;

  done_t done_q[$];
  bus_t  bus_q[$];

  int          gnt_wait = 0;
  int          rd_lat = 1;
  int          wcnt = 0;
  int          rv_cnt = 0;
  logic [31:0] rd_data = '0;
  bit          stray_rv = 1'b0;

  dmem_bus_arbiter_if bus();

  dmem_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic exp_done(input bit port, input bit chk_rd, input logic [31:0] rdata,
                          input logic err, input int c);
    done_t d;
    d = '{port: port, chk_rd: chk_rd, rdata: rdata, err: err, cyc: c};
    done_q.push_back(d);
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
    bus_t b;
    b = '{we: we, addr: addr, wdata: wdata, be: be};
    bus_q.push_back(b);
  endtask

  // Caller is at posedge+1; holds the request until done, then drops it on the next cycle.
  task automatic drive(input bit port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int k;
    k = 0;
    if (!port) begin
      bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_be = be;
    end else begin
      bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata; bus.l_be = be;
    end
    do begin
      @(negedge clock);
      k++;
    end while (!(port ? bus.l_done : bus.c_done) && k < 200);
    if (k >= 200) check("done_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    if (!port) bus.c_req = 1'b0;
    else       bus.l_req = 1'b0;
  endtask

  // Memory model: grant after gnt_wait cycles of mem_req, rvalid rd_lat cycles after a read grant.
  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'hBAD0_0000 + 32'(cyc);
      if (stray_rv) begin
        bus.mem_rvalid = 1'b1;
        stray_rv = 1'b0;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rd_data;
        end
      end
      if (bus.mem_req) begin
        if (wcnt >= gnt_wait) begin
          bus.mem_gnt = 1'b1;
          wcnt = 0;
          if (!bus.mem_we && rd_lat > 0) rv_cnt = rd_lat;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT completes or the bus accepts a request.
  initial begin
    done_t d;
    bus_t  b;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.c_done || bus.l_done) begin
          if (done_q.size() == 0) begin
            unexp_done++;
            check("done_expected", {bus.l_done, bus.c_done}, 32'd0);
          end else begin
            d = done_q.pop_front();
            check("done_port_c", bus.c_done, !d.port);
            check("done_port_l", bus.l_done, d.port);
            check("done_cycle", cyc, d.cyc);
            if (!d.port) begin
              check("c_err", bus.c_err, d.err);
              if (d.chk_rd) check("c_rdata", bus.c_rdata, d.rdata);
              check("l_idle_outputs", {bus.l_err, bus.l_rdata[30:0]} | 32'(bus.l_rdata[31]), 32'd0);
            end else begin
              check("l_err", bus.l_err, d.err);
              if (d.chk_rd) check("l_rdata", bus.l_rdata, d.rdata);
              check("c_idle_outputs", {bus.c_err, bus.c_rdata[30:0]} | 32'(bus.c_rdata[31]), 32'd0);
            end
          end
        end
        if (bus.mem_req && bus.mem_gnt) begin
          if (bus_q.size() == 0) begin
            check("bus_expected", 32'd1, 32'd0);
          end else begin
            b = bus_q.pop_front();
            check("mem_we", bus.mem_we, b.we);
            check("mem_addr", bus.mem_addr, b.addr);
            if (b.we) check("mem_wdata", bus.mem_wdata, b.wdata);
            check("mem_be", bus.mem_be, b.be);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_be = '0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0; bus.l_be = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_c_done", bus.c_done, 1'b0);
    check("rst_l_done", bus.l_done, 1'b0);
    check("rst_core_stall", bus.core_stall, 1'b0);

    // Tie out of reset: core first, held loader next.
    @(posedge clock); #1;
    n = cyc;
    exp_bus(1'b1, 32'h200, 32'h1, 4'hF);
    exp_bus(1'b1, 32'h300, 32'h2, 4'hF);
    exp_done(1'b0, 1'b0, '0, 1'b0, n + 2);
    exp_done(1'b1, 1'b0, '0, 1'b0, n + 5);
    fork
      drive(1'b0, 1'b1, 32'h200, 32'h1, 4'hF);
      drive(1'b1, 1'b1, 32'h300, 32'h2, 4'hF);
    join

    // Core alone, then a tie which the loader must win.
    n = cyc;
    exp_bus(1'b1, 32'h204, 32'h3, 4'hF);
    exp_done(1'b0, 1'b0, '0, 1'b0, n + 2);
    drive(1'b0, 1'b1, 32'h204, 32'h3, 4'hF);

    n = cyc;
    rd_lat = 1; rd_data = 32'hA5A5_0001;
    exp_bus(1'b0, 32'h308, '0, 4'hF);
    exp_bus(1'b1, 32'h208, 32'h4, 4'h3);
    exp_done(1'b1, 1'b1, 32'hA5A5_0001, 1'b0, n + 3);
    exp_done(1'b0, 1'b0, '0, 1'b0, n + 6);
    fork
      drive(1'b0, 1'b1, 32'h208, 32'h4, 4'h3);
      drive(1'b1, 1'b0, 32'h308, '0, 4'hF);
    join

    // Core write, immediate grant.
    n = cyc;
    exp_bus(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    exp_done(1'b0, 1'b0, '0, 1'b0, n + 2);
    fork
      drive(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
      begin
        @(negedge clock);
        @(negedge clock); check("wr_mem_req_issue", bus.mem_req, 1'b1);
        @(negedge clock); check("wr_mem_req_resp", bus.mem_req, 1'b0);
      end
    join

    // Core read, rvalid one cycle after grant; stall until done.
    n = cyc;
    rd_lat = 1; rd_data = 32'h1234_5678;
    exp_bus(1'b0, 32'h40, '0, 4'hF);
    exp_done(1'b0, 1'b1, 32'h1234_5678, 1'b0, n + 3);
    fork
      drive(1'b0, 1'b0, 32'h40, '0, 4'hF);
      for (int i = 0; i < 4; i++) begin
        @(negedge clock);
        check($sformatf("rd_core_stall_%0d", i), bus.core_stall, (i < 3) ? 1'b1 : 1'b0);
      end
    join

    // Read timeout, then a stray rvalid.
    n = cyc;
    rd_lat = 0;
    exp_bus(1'b0, 32'h80, '0, 4'hF);
    exp_done(1'b0, 1'b1, 32'h0, 1'b1, n + 2 + MAX_WAIT + 1);
    drive(1'b0, 1'b0, 32'h80, '0, 4'hF);
    stray_rv = 1'b1;
    repeat (4) @(negedge clock);
    check("late_rvalid_ignored", unexp_done, 0);

    // Grant withheld five cycles.
    @(posedge clock); #1;
    n = cyc;
    gnt_wait = 5; rd_lat = 1;
    exp_bus(1'b1, 32'h500, 32'h0BAD_F00D, 4'h3);
    exp_done(1'b0, 1'b0, '0, 1'b0, n + 7);
    fork
      drive(1'b0, 1'b1, 32'h500, 32'h0BAD_F00D, 4'h3);
      begin
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          check($sformatf("hold_mem_req_%0d", i), bus.mem_req, 1'b1);
          check($sformatf("hold_mem_addr_%0d", i), bus.mem_addr, 32'h500);
          check($sformatf("hold_mem_wdata_%0d", i), bus.mem_wdata, 32'h0BAD_F00D);
        end
      end
    join
    gnt_wait = 0;

    // Reset during WAIT_RD; the pending rvalid lands in IDLE.
    n = cyc;
    rd_lat = 4; rd_data = 32'h7777_7777;
    exp_bus(1'b0, 32'h600, '0, 4'hF);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h600; bus.c_be = 4'hF;
    repeat (3) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    bus.c_req = 1'b0;
    @(negedge clock);
    check("rst_wait_mem_req", bus.mem_req, 1'b0);
    check("rst_wait_mem_addr", bus.mem_addr, 32'd0);
    check("rst_wait_c_done", bus.c_done, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_no_done", unexp_done, 0);

    @(posedge clock); #1;
    n = cyc;
    rd_lat = 1; rd_data = 32'hCAFE_F00D;
    exp_bus(1'b0, 32'h604, '0, 4'hF);
    exp_done(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, n + 3);
    drive(1'b0, 1'b0, 32'h604, '0, 4'hF);

    repeat (3) @(negedge clock);
    check("done_q_drained", done_q.size(), 0);
    check("bus_q_drained", bus_q.size(), 0);
    check("no_unexpected_done", unexp_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
Shares one data-memory bus between two requesters: the single-cycle core's data port (port C) and a loader/debug port (port L) that fills or inspects memory.
- Sequences each access through a request/grant/read-valid protocol with round-robin tie-break and a read timeout.
- Drives a stall to the core control path so `pc_write_enable` is held while a core access is outstanding.
- Sits between `riscv_core` bus outputs and the memory model.

Parameters:
MAX_WAIT, 15, max cycles in WAIT_RD after grant before a read completes with error.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
c_req  in  1  core request; held with fields stable until c_done
c_we  in  1  core write (1) / read (0)
c_addr  in  32  core byte address
c_wdata  in  32  core write data
c_be  in  4  core byte enables
c_done  out  1  one-cycle completion pulse to core
c_rdata  out  32  core read data, valid with c_done
c_err  out  1  core timeout error, valid with c_done
l_req, l_we, l_addr, l_wdata, l_be  in  1/1/32/32/4  loader request, same rules as core
l_done, l_rdata, l_err  out  1/32/1  loader completion, same rules as core
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  32  bus address
mem_wdata  out  32  bus write data
mem_be  out  4  bus byte enables
mem_gnt  in  1  bus accepts the current mem_req
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
core_stall  out  1  c_req & ~c_done (combinational)

Behaviour:
- States: IDLE, ISSUE, WAIT_RD, RESP.
- Registers: owner (C/L), last_owner, latched command (we, addr, wdata, be), rdata, err, wait counter of width $clog2(MAX_WAIT+1).
- Reset, asynchronous:
  - state=IDLE, last_owner=L so the core wins the first tie.
  - All outputs, latched fields, counter, rdata and err = 0.
- Reset mid-transaction: access is abandoned; no done is issued. The memory side must tolerate a dropped mem_req.

IDLE:
- If only one req is high, that port wins.
- If both are high, the winner is the port != last_owner.
- Latch the winner's command, set owner, go to ISSUE.
- With no req, stay in IDLE.

ISSUE:
- mem_req=1 with the latched fields (registered; no combinational path from c_*/l_* to mem_*).
- mem_gnt & we -> RESP, err=0.
- mem_gnt & ~we -> WAIT_RD, counter=0.
- With no gnt, hold indefinitely (no timeout in ISSUE).

WAIT_RD:
- mem_req=0.
- mem_rvalid -> capture mem_rdata, err=0, go to RESP.
- Else, counter==MAX_WAIT -> rdata=0, err=1, go to RESP.
- Else, counter++.

RESP:
- Owner's done=1 for exactly one cycle; rdata/err are driven to the owner. The non-owner's outputs stay 0.
- last_owner=owner; go to IDLE.

General rules:
- mem_rvalid outside WAIT_RD is ignored.
- mem_rdata is captured only on rvalid.
- Requester drops req or presents the next request on the cycle after done; IDLE samples after RESP, so back-to-back works.
- Latency, request first seen in IDLE at cycle N:
  - Write with immediate gnt: done at N+2.
  - Read with gnt at N+1 and rvalid at N+2: done at N+3.
  - Read timeout: done at N+2+MAX_WAIT+1.
- core_stall is high from c_req until c_done, including the cycles lost while L owns the bus.

Decomposition:
- Shared package holds the state enum (IDLE/ISSUE/WAIT_RD/RESP) and the owner enum (OWNER_C/OWNER_L).
- Single module, no sub-module; the round-robin pick is a two-input expression.

Test Plan:
1. Core write, L idle: c_req=1, c_we=1, addr=0x100, wdata=0xDEADBEEF, be=0xF; gnt at first ISSUE cycle -> mem_req one cycle with those fields; c_done at N+2; l_done=0.
2. Core read: addr=0x40; gnt immediate, rvalid+rdata=0x12345678 one cycle later -> c_done at N+3 with c_rdata=0x12345678, c_err=0; core_stall high N..N+2.
3. Simultaneous c_req and l_req out of reset -> core served first. L holds req -> served next. Then both re-request -> L wins the tie (last_owner=C).
4. Read timeout: gnt given, rvalid never -> c_done exactly MAX_WAIT+1 cycles after WAIT_RD entry (16 cycles at default), c_rdata=0, c_err=1. A late rvalid afterwards is ignored.
5. ISSUE with gnt withheld 5 cycles -> mem_req and fields stable all 5 cycles, no timeout; completes normally after gnt.
6. Assert reset while in WAIT_RD -> next cycle state IDLE, mem_req=0, no done pulses. A later rvalid is ignored, and a subsequent core read completes normally.
